sdram_sim_model: RTL and testbench
==================================

// Module: sdram_sim_model
// PURPOSE
//  Cycle-level behavioural SDR SDRAM for the simulation top; the sdram controller's pins connect here, not to a bench stub.
//  Parametrised in data width, banks, row/column widths, CAS latency and burst length. Enforces the command protocol.
//  Flags protocol violations so the controller and macplus bus phasing can be checked end to end.
// PARAMETERS
//  DATA_W    32  data bus width; multiple of 8, DQM width = DATA_W/8
//  ADDR_W    11  multiplexed address width (A10 = auto-precharge bit)
//  BA_W      2   bank address width; BANKS = 2**BA_W
//  ROW_W     11  row address bits taken from sd_addr[ROW_W-1:0]
//  COL_W     8   column bits taken from sd_addr[COL_W-1:0]; memory index = {ba,row,col}
//  INIT_ZERO 1   1: array zero-filled at time 0; 0: left X
// PORTS
//  clk           in   1            SDRAM clock, all logic on rising edge
//  reset         in   1            synchronous, active-high
//  sd_cke        in   1            clock enable; 0 freezes all state
//  sd_cs         in   1            chip select, active-low
//  sd_ras        in   1            active-low
//  sd_cas        in   1            active-low
//  sd_we         in   1            active-low
//  sd_ba         in   BA_W         bank address
//  sd_addr       in   ADDR_W       row / column / mode address
//  sd_dqm        in   DATA_W/8     byte masks, 1 = masked
//  sd_data_in    in   DATA_W       write data from the controller
//  sd_data_out   out  DATA_W       read data to the controller
//  sd_data_oe    out  1            1 while sd_data_out carries a read word
//  protocol_err  out  1            one-cycle pulse per violation
//  refresh_count out  16           AUTO REFRESH commands accepted, wraps at 16'hFFFF
// BEHAVIOUR
//  Reset: all banks closed, mode invalid, burst and CAS pipeline cleared. sd_data_out=0, sd_data_oe=0,
//   protocol_err=0, refresh_count=0. Array contents untouched. Reset mid-burst: no read word appears on the next cycle.
//  Command decode is sampled each edge when cke=1 and cs=0. {ras,cas,we}:
//   111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE (A10=1: all banks), 001 AUTO REFRESH, 000 LOAD MODE, 110 BURST TERMINATE.
//   cs=1 is treated as NOP.
//  Mode register: addr[2:0] burst length 000=1, 001=2, 010=4, 011=8; addr[6:4] CAS latency 2 or 3.
//   Any other encoding -> protocol_err, mode unchanged.
//  Per-bank state: IDLE / ACTIVE(row). ACTIVE on an open bank -> err, row unchanged. PRECHARGE on an idle bank is legal.
//  READ/WRITE: errors, with no access, if the mode is invalid or the bank is idle. Otherwise a burst starts at col;
//   the address increments sequentially and wraps inside the BL-aligned block (col[log2 BL-1:0] only).
//  WRITE: word 0 is taken in the command cycle, one word per cycle after that. Byte i is written only if dqm[i]=0 in that cycle.
//  READ: the burst generator issues one word per cycle into a CL-deep pipeline.
//   The word addressed at command edge N is presented on sd_data_out/oe after edge N+CL.
//   dqm sampled at edge t masks the word output after edge t+2; masked bytes read 8'h00, oe stays 1.
//  A new READ/WRITE, BURST TERMINATE, or PRECHARGE of the burst bank stops further issue the same cycle.
//   Words already in the pipeline still emerge.
//  Auto-precharge (A10=1 on READ/WRITE): the bank goes IDLE after the last burst word is issued.
//  AUTO REFRESH with any bank open -> err, not counted. Otherwise refresh_count+1.
//  cke=0: command ignored, burst and pipeline hold, outputs hold.
//  Simultaneous err causes in one cycle give a single pulse.
// TESTING
//  1 LOAD MODE addr=0x020 (CL2, BL1); ACTIVE b1 r5; WRITE col 3 data 0xDEADBEEF dqm 0;
//    READ col 3 at edge N -> 0xDEADBEEF with oe=1 after edge N+2 only.
//  2 Mode 0x032 (CL3, BL4); write 4 words at col 6 -> stored at col 6,7,4,5.
//    READ col 6 -> data at N+3..N+6 in that order.
//  3 WRITE 0x11223344 with dqm=4'b0101 over 0xAAAAAAAA -> 0x11AA33AA.
//    Read with dqm=4'b1000 two edges before the output word -> 0x00AA33AA.
//  4 READ to idle bank; ACTIVE twice on a bank; mode addr=0x050; REFRESH with b0 open
//    -> one err pulse each, refresh_count stays 0.
//  5 BL8 read, BURST TERMINATE at N+2 -> exactly 2 words out.
//    Then reset asserted mid-burst -> oe=0 on the next cycle, all banks IDLE.
//  6 cke=0 for 3 cycles during a CL3 read -> the output stream stretches by 3 cycles, data unchanged.

Source files
------------

// File: rtl/sdram_sim_model.sv
// Cycle-level SDR SDRAM model: decodes the command bus, tracks bank and mode state, and flags protocol violations.
// Latency: read word addressed at command edge N is driven after edge N+CL; write words are taken at edges N..N+BL-1.
// Backpressure: none; cke=0 freezes every register, including the burst and read pipeline.
module sdram_sim_model #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 11,
    parameter int BA_W      = 2,
    parameter int ROW_W     = 11,
    parameter int COL_W     = 8,
    parameter int INIT_ZERO = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sd_cke,
    input  logic                sd_cs,
    input  logic                sd_ras,
    input  logic                sd_cas,
    input  logic                sd_we,
    input  logic [BA_W-1:0]     sd_ba,
    input  logic [ADDR_W-1:0]   sd_addr,
    input  logic [DATA_W/8-1:0] sd_dqm,
    input  logic [DATA_W-1:0]   sd_data_in,
    output logic [DATA_W-1:0]   sd_data_out,
    output logic                sd_data_oe,
    output logic                protocol_err,
    output logic [15:0]         refresh_count
);
    localparam int BANKS  = 2 ** BA_W;
    localparam int NB     = DATA_W / 8;
    localparam int MEM_AW = BA_W + ROW_W + COL_W;
    localparam int AP_BIT = 10;

    localparam logic [2:0] CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
                           CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111;

    logic [DATA_W-1:0] mem [2**MEM_AW];

    logic              mode_vld_q, mode_vld_d;
    logic [3:0]        bl_q, bl_d;
    logic [1:0]        cl_q, cl_d;
    logic [BANKS-1:0]  bank_open_q, bank_open_d;
    logic [ROW_W-1:0]  bank_row_q [BANKS];
    logic [ROW_W-1:0]  bank_row_d [BANKS];
    logic              burst_act_q, burst_act_d, burst_wr_q, burst_wr_d, burst_ap_q, burst_ap_d;
    logic [BA_W-1:0]   burst_ba_q, burst_ba_d;
    logic [ROW_W-1:0]  burst_row_q, burst_row_d;
    logic [COL_W-1:0]  burst_col_q, burst_col_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic [2:0]        p_vld_q, p_vld_d;
    logic [DATA_W-1:0] p_dat_q [3];
    logic [DATA_W-1:0] p_dat_d [3];
    logic [NB-1:0]     dqm1_q, dqm1_d, dqm2_q, dqm2_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_oe_q, data_oe_d, protocol_err_q, protocol_err_d;
    logic [15:0]       refresh_count_q, refresh_count_d;

    logic [2:0]        cmd;
    logic              is_rw, rw_ok, stop, iss_vld, iss_wr, iss_ap, sel_vld;
    logic [BA_W-1:0]   iss_ba;
    logic [ROW_W-1:0]  iss_row;
    logic [COL_W-1:0]  iss_col, iss_col_nxt, col_mask;
    logic [3:0]        iss_left;
    logic [MEM_AW-1:0] mem_idx;
    logic [DATA_W-1:0] rd_word, sel_dat;

    // Burst issue: a legal READ/WRITE issues word 0 now; otherwise an unstopped burst issues its next word.
    always_comb begin
        cmd      = sd_cs ? CMD_NOP : {sd_ras, sd_cas, sd_we};
        is_rw    = (cmd == CMD_RD) || (cmd == CMD_WR);
        rw_ok    = is_rw && mode_vld_q && bank_open_q[sd_ba];
        stop     = is_rw || (cmd == CMD_BST) ||
                   ((cmd == CMD_PRE) && (sd_addr[AP_BIT] || (sd_ba == burst_ba_q)));
        iss_vld  = burst_act_q && !stop;
        iss_wr   = burst_wr_q;
        iss_ap   = burst_ap_q;
        iss_ba   = burst_ba_q;
        iss_row  = burst_row_q;
        iss_col  = burst_col_q;
        iss_left = burst_cnt_q - 4'd1;
        if (rw_ok) begin
            iss_vld  = 1'b1;
            iss_wr   = (cmd == CMD_WR);
            iss_ap   = sd_addr[AP_BIT];
            iss_ba   = sd_ba;
            iss_row  = bank_row_q[sd_ba];
            iss_col  = sd_addr[COL_W-1:0];
            iss_left = bl_q - 4'd1;
        end
        col_mask    = COL_W'(bl_q - 4'd1);
        iss_col_nxt = (iss_col & ~col_mask) | ((iss_col + COL_W'(1)) & col_mask);
        mem_idx     = {iss_ba, iss_row, iss_col};

        burst_act_d = iss_vld && (iss_left != 4'd0);
        burst_wr_d  = iss_wr;
        burst_ap_d  = iss_ap;
        burst_ba_d  = iss_ba;
        burst_row_d = iss_row;
        burst_col_d = iss_col_nxt;
        burst_cnt_d = iss_left;
    end

    // Bank, mode and refresh bookkeeping; all violation causes fold into one pulse.
    always_comb begin
        mode_vld_d      = mode_vld_q;
        bl_d            = bl_q;
        cl_d            = cl_q;
        bank_open_d     = bank_open_q;
        bank_row_d      = bank_row_q;
        protocol_err_d  = 1'b0;
        refresh_count_d = refresh_count_q;
        if (iss_vld && (iss_left == 4'd0) && iss_ap)
            bank_open_d[iss_ba] = 1'b0;
        case (cmd)
            CMD_ACT: begin
                if (bank_open_q[sd_ba]) begin
                    protocol_err_d = 1'b1;
                end else begin
                    bank_open_d[sd_ba] = 1'b1;
                    bank_row_d[sd_ba]  = sd_addr[ROW_W-1:0];
                end
            end
            CMD_PRE: begin
                if (sd_addr[AP_BIT]) bank_open_d = '0;
                else                 bank_open_d[sd_ba] = 1'b0;
            end
            CMD_RD, CMD_WR: protocol_err_d = !rw_ok;
            CMD_REF: begin
                if (|bank_open_q) protocol_err_d = 1'b1;
                else              refresh_count_d = refresh_count_q + 16'd1;
            end
            CMD_LMR: begin
                if ((sd_addr[2:0] <= 3'd3) && ((sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3))) begin
                    mode_vld_d = 1'b1;
                    bl_d       = 4'd1 << sd_addr[1:0];
                    cl_d       = sd_addr[5:4];
                end else begin
                    protocol_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Read pipeline: words enter stage 0 at issue; CL selects the stage feeding the output register.
    always_comb begin
        rd_word = mem[mem_idx];
        if (INIT_ZERO != 0)
            for (int b = 0; b < DATA_W; b++) rd_word[b] = (rd_word[b] === 1'b1);
        p_vld_d    = {p_vld_q[1:0], iss_vld && !iss_wr};
        p_dat_d[0] = rd_word;
        p_dat_d[1] = p_dat_q[0];
        p_dat_d[2] = p_dat_q[1];
        dqm1_d     = sd_dqm;
        dqm2_d     = dqm1_q;
        sel_vld    = (cl_q == 2'd3) ? p_vld_q[2] : p_vld_q[1];
        sel_dat    = (cl_q == 2'd3) ? p_dat_q[2] : p_dat_q[1];
        data_oe_d  = sel_vld;
        data_out_d = '0;
        if (sel_vld)
            for (int i = 0; i < NB; i++)
                data_out_d[8*i +: 8] = dqm2_q[i] ? 8'h00 : sel_dat[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_vld_q      <= 1'b0;
            bl_q            <= 4'd1;
            cl_q            <= 2'd2;
            bank_open_q     <= '0;
            bank_row_q      <= '{default: '0};
            burst_act_q     <= 1'b0;
            burst_wr_q      <= 1'b0;
            burst_ap_q      <= 1'b0;
            burst_ba_q      <= '0;
            burst_row_q     <= '0;
            burst_col_q     <= '0;
            burst_cnt_q     <= '0;
            p_vld_q         <= '0;
            p_dat_q         <= '{default: '0};
            dqm1_q          <= '0;
            dqm2_q          <= '0;
            data_out_q      <= '0;
            data_oe_q       <= 1'b0;
            protocol_err_q  <= 1'b0;
            refresh_count_q <= '0;
        end else if (sd_cke) begin
            mode_vld_q      <= mode_vld_d;
            bl_q            <= bl_d;
            cl_q            <= cl_d;
            bank_open_q     <= bank_open_d;
            bank_row_q      <= bank_row_d;
            burst_act_q     <= burst_act_d;
            burst_wr_q      <= burst_wr_d;
            burst_ap_q      <= burst_ap_d;
            burst_ba_q      <= burst_ba_d;
            burst_row_q     <= burst_row_d;
            burst_col_q     <= burst_col_d;
            burst_cnt_q     <= burst_cnt_d;
            p_vld_q         <= p_vld_d;
            p_dat_q         <= p_dat_d;
            dqm1_q          <= dqm1_d;
            dqm2_q          <= dqm2_d;
            data_out_q      <= data_out_d;
            data_oe_q       <= data_oe_d;
            protocol_err_q  <= protocol_err_d;
            refresh_count_q <= refresh_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && sd_cke && iss_vld && iss_wr) begin
            for (int i = 0; i < NB; i++)
                if (!sd_dqm[i]) mem[mem_idx][8*i +: 8] <= sd_data_in[8*i +: 8];
        end
    end

    assign sd_data_out   = data_out_q;
    assign sd_data_oe    = data_oe_q;
    assign protocol_err  = protocol_err_q;
    assign refresh_count = refresh_count_q;
endmodule

// File: tb/tb_sdram_sim_model.sv
// Directed bench for sdram_sim_model: expected read words (value and output edge) go into a scoreboard queue.
module tb_sdram_sim_model;
    localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
                           C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110;
    localparam logic [31:0] W0 = 32'h01234567, W1 = 32'h89ABCDEF, W2 = 32'h13579BDF, W3 = 32'h2468ACE0;

    logic        clk = 1'b0;
    logic        reset, sd_cke, sd_cs, sd_ras, sd_cas, sd_we;
    logic [1:0]  sd_ba;
    logic [10:0] sd_addr;
    logic [3:0]  sd_dqm;
    logic [31:0] sd_data_in, sd_data_out;
    logic        sd_data_oe, protocol_err;
    logic [15:0] refresh_count;

    typedef struct {
        logic [31:0] d;
        int          e;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0, n_bad = 0, err_cnt = 0, edge_n = 0, e0, n;
    bit upd = 1'b0;

    sdram_sim_model dut (
        .clk(clk), .reset(reset), .sd_cke(sd_cke), .sd_cs(sd_cs), .sd_ras(sd_ras), .sd_cas(sd_cas),
        .sd_we(sd_we), .sd_ba(sd_ba), .sd_addr(sd_addr), .sd_dqm(sd_dqm), .sd_data_in(sd_data_in),
        .sd_data_out(sd_data_out), .sd_data_oe(sd_data_oe), .protocol_err(protocol_err),
        .refresh_count(refresh_count)
    );

    always #5 clk = ~clk;

    // upd marks edges where the DUT was clocked, so held outputs during cke=0 are not re-counted.
    always @(posedge clk) begin
        edge_n++;
        upd = sd_cke;
    end

    always @(negedge clk) begin
        exp_t e;
        if (upd && protocol_err) err_cnt++;
        if (upd && sd_data_oe) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_word: got %h at edge %0d, no word expected", sd_data_out, edge_n);
            end else begin
                e = exp_q.pop_front();
                if (sd_data_out !== e.d || edge_n != e.e) begin
                    n_bad++;
                    $display("FAIL read_word: got %h at edge %0d, expected %h at edge %0d",
                             sd_data_out, edge_n, e.d, e.e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [10:0] a,
                       input logic [31:0] d = 32'h0, input logic [3:0] m = 4'h0);
        sd_cs = 1'b0;
        {sd_ras, sd_cas, sd_we} = c;
        sd_ba = ba;
        sd_addr = a;
        sd_data_in = d;
        sd_dqm = m;
        tick();
        sd_cs = 1'b1;
        {sd_ras, sd_cas, sd_we} = 3'b111;
        sd_dqm = 4'h0;
    endtask

    task automatic push(input logic [31:0] d, input int e);
        exp_t x;
        x.d = d;
        x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sd_cke = 1'b1; sd_cs = 1'b1; {sd_ras, sd_cas, sd_we} = 3'b111;
        sd_ba = '0; sd_addr = '0; sd_dqm = '0; sd_data_in = '0;
        repeat (3) tick();
        check("rst_oe", 32'(sd_data_oe), 32'd0);
        check("rst_data", sd_data_out, 32'd0);
        check("rst_err", 32'(protocol_err), 32'd0);
        check("rst_refcnt", 32'(refresh_count), 32'd0);
        reset = 1'b0;
        tick();

        // CL2 BL1 single write then read
        cmd(C_LMR, 2'd0, 11'h020);
        cmd(C_ACT, 2'd1, 11'd5);
        cmd(C_WR, 2'd1, 11'd3, 32'hDEADBEEF);
        cmd(C_RD, 2'd1, 11'd3); push(32'hDEADBEEF, edge_n + 2);
        repeat (4) tick();

        // CL3 BL4 wrapping burst
        cmd(C_LMR, 2'd0, 11'h032);
        cmd(C_WR, 2'd1, 11'd6, W0);
        sd_data_in = W1; tick();
        sd_data_in = W2; tick();
        sd_data_in = W3; tick();
        cmd(C_RD, 2'd1, 11'd6); n = edge_n;
        push(W0, n + 3); push(W1, n + 4); push(W2, n + 5); push(W3, n + 6);
        repeat (6) tick();
        cmd(C_RD, 2'd1, 11'd4); n = edge_n;
        push(W2, n + 3); push(W3, n + 4); push(W0, n + 5); push(W1, n + 6);
        repeat (7) tick();

        // byte masks on write and on read
        cmd(C_LMR, 2'd0, 11'h020);
        cmd(C_WR, 2'd1, 11'd10, 32'hAAAAAAAA);
        cmd(C_WR, 2'd1, 11'd10, 32'h11223344, 4'b0101);
        cmd(C_RD, 2'd1, 11'd10); push(32'h11AA33AA, edge_n + 2);
        cmd(C_RD, 2'd1, 11'd10, 32'h0, 4'b1000); push(32'h00AA33AA, edge_n + 2);
        repeat (4) tick();

        // protocol violations
        cmd(C_PRE, 2'd0, 11'h400);
        repeat (2) tick();
        e0 = err_cnt; cmd(C_RD, 2'd2, 11'd0); repeat (2) tick();
        check("err_read_idle", 32'(err_cnt - e0), 32'd1);
        e0 = err_cnt; cmd(C_ACT, 2'd0, 11'd1); cmd(C_ACT, 2'd0, 11'd2); repeat (2) tick();
        check("err_act_twice", 32'(err_cnt - e0), 32'd1);
        e0 = err_cnt; cmd(C_LMR, 2'd0, 11'h050); repeat (2) tick();
        check("err_bad_mode", 32'(err_cnt - e0), 32'd1);
        e0 = err_cnt; cmd(C_REF, 2'd0, 11'd0); repeat (2) tick();
        check("err_ref_open", 32'(err_cnt - e0), 32'd1);
        check("refcnt_blocked", 32'(refresh_count), 32'd0);
        cmd(C_WR, 2'd0, 11'd20, 32'hCAFEF00D);
        cmd(C_RD, 2'd0, 11'd20); push(32'hCAFEF00D, edge_n + 2);
        repeat (4) tick();
        e0 = err_cnt; cmd(C_PRE, 2'd0, 11'h000); cmd(C_REF, 2'd0, 11'd0); tick(); tick();
        check("refcnt_ok", 32'(refresh_count), 32'd1);
        check("no_err_legal_ref", 32'(err_cnt - e0), 32'd0);

        // BL8 read cut by BURST TERMINATE, then reset mid-burst
        cmd(C_LMR, 2'd0, 11'h023);
        cmd(C_ACT, 2'd1, 11'd5);
        cmd(C_RD, 2'd1, 11'd4); n = edge_n;
        push(W2, n + 2); push(W3, n + 3);
        tick();
        cmd(C_BST, 2'd0, 11'd0);
        repeat (8) tick();
        cmd(C_RD, 2'd1, 11'd4); push(W2, edge_n + 2);
        tick(); tick();
        reset = 1'b1; tick();
        check("rst_mid_oe", 32'(sd_data_oe), 32'd0);
        check("rst_mid_refcnt", 32'(refresh_count), 32'd0);
        reset = 1'b0;
        repeat (10) tick();
        e0 = err_cnt; cmd(C_LMR, 2'd0, 11'h020); cmd(C_RD, 2'd1, 11'd4); repeat (2) tick();
        check("err_bank_idle_after_rst", 32'(err_cnt - e0), 32'd1);
        cmd(C_REF, 2'd0, 11'd0); tick();
        check("refcnt_after_rst", 32'(refresh_count), 32'd1);

        // cke stall during a CL3 BL4 read
        cmd(C_LMR, 2'd0, 11'h032);
        cmd(C_ACT, 2'd1, 11'd5);
        cmd(C_RD, 2'd1, 11'd4); n = edge_n;
        push(W2, n + 6); push(W3, n + 7); push(W0, n + 8); push(W1, n + 9);
        tick();
        sd_cke = 1'b0; repeat (3) tick();
        sd_cke = 1'b1; repeat (12) tick();

        while (exp_q.size() != 0) begin
            exp_t x;
            x = exp_q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL missing_word: got nothing, expected %h at edge %0d", x.d, x.e);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
